// File: rtl/bt_pkg.sv
// Shared slot-controller definitions: FSM encoding, timer defaults, packet types.
package bt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TXARM,
    ST_TX,
    ST_RXWIN,
    ST_RX
  } pk_state_e;

  localparam int unsigned RXWIN_US_DEF   = 20;
  localparam int unsigned RXSTALL_US_DEF = 400;
  localparam int unsigned US_CNT_W       = 9;

  localparam logic [3:0] PKT_NULL = 4'b0000;
  localparam logic [3:0] PKT_POLL = 4'b0001;
  localparam logic [3:0] PKT_FHS  = 4'b0010;

  function automatic logic is_lc_pkt(input logic [3:0] pkt_type);
    return (pkt_type == PKT_NULL) || (pkt_type == PKT_POLL) || (pkt_type == PKT_FHS);
  endfunction

  // Saturating microsecond counter step; holds at all-ones instead of wrapping.
  function automatic logic [US_CNT_W-1:0] us_sat_inc(input logic [US_CNT_W-1:0] cnt,
                                                     input logic               tick);
    return (tick && (cnt != '1)) ? cnt + 1'b1 : cnt;
  endfunction

endpackage

// File: rtl/arq_track.sv
// ARQN/SEQN bookkeeping for the slot controller, plus the slave reply flag.
module arq_track
  import bt_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_done_i,
  input  logic lt_addressed_i,
  input  logic rx_arqn_i,
  input  logic rx_seqn_i,
  input  logic rx_crc_good_i,
  input  logic tx_pending_i,
  input  logic retx_i,
  input  logic slave_i,
  input  logic txarm_enter_i,
  output logic txarqn_o,
  output logic txseqn_o,
  output logic tx_new_o,
  output logic addr_flag_o
);

  logic txarqn_q, txarqn_d;
  logic txseqn_q, txseqn_d;
  logic tx_new_q, tx_new_d;
  logic last_seqn_q, last_seqn_d;
  logic seqn_vld_q, seqn_vld_d;
  logic addr_flag_q, addr_flag_d;
  logic rx_hit;

  assign rx_hit = rx_done_i && lt_addressed_i;

  always_comb begin
    txarqn_d    = txarqn_q;
    txseqn_d    = txseqn_q;
    tx_new_d    = tx_new_q;
    last_seqn_d = last_seqn_q;
    seqn_vld_d  = seqn_vld_q;
    addr_flag_d = addr_flag_q;
    if (rx_hit) begin
      // Duplicates are still acknowledged; only a fresh SEQN updates the history.
      txarqn_d = rx_crc_good_i;
      if (rx_crc_good_i && (!seqn_vld_q || (rx_seqn_i != last_seqn_q))) begin
        last_seqn_d = rx_seqn_i;
        seqn_vld_d  = 1'b1;
      end
      if (rx_arqn_i) begin
        txseqn_d = ~txseqn_q;
        tx_new_d = tx_pending_i;
      end else begin
        tx_new_d = 1'b0;
      end
      if (slave_i) addr_flag_d = 1'b1;
    end else if (retx_i) begin
      tx_new_d = 1'b0;
    end
    if (txarm_enter_i) addr_flag_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      txarqn_q    <= 1'b0;
      txseqn_q    <= 1'b1;
      tx_new_q    <= 1'b1;
      last_seqn_q <= 1'b0;
      seqn_vld_q  <= 1'b0;
      addr_flag_q <= 1'b0;
    end else begin
      txarqn_q    <= txarqn_d;
      txseqn_q    <= txseqn_d;
      tx_new_q    <= tx_new_d;
      last_seqn_q <= last_seqn_d;
      seqn_vld_q  <= seqn_vld_d;
      addr_flag_q <= addr_flag_d;
    end
  end

  assign txarqn_o    = txarqn_q;
  assign txseqn_o    = txseqn_q;
  assign tx_new_o    = tx_new_q;
  assign addr_flag_o = addr_flag_q;

endmodule

// File: rtl/pkslot_ctrl.sv
// Per-slot packet controller: picks tx/rx each slot, runs the search/stall timers.
module pkslot_ctrl
  import bt_pkg::*;
#(
  parameter int unsigned RXWIN_US   = RXWIN_US_DEF,
  parameter int unsigned RXSTALL_US = RXSTALL_US_DEF
) (
  input  logic clk_6M,
  input  logic rstz,
  input  logic p_1us,
  input  logic s_tslot_p,
  input  logic slot_odd,
  input  logic conns,
  input  logic master,
  input  logic tx_pending,
  input  logic corr_hit_p,
  input  logic hdr_period,
  input  logic lt_addressed,
  input  logic rx_arqn,
  input  logic rx_seqn,
  input  logic rx_crc_good,
  input  logic rx_done_p,
  output logic tx_packet_st_p,
  output logic rx_trailer_st_p,
  output logic pk_encode,
  output logic rx_window,
  output logic txarqn,
  output logic txseqn,
  output logic tx_new,
  output logic rx_timeout_p
);

  localparam logic [US_CNT_W-1:0] WIN_LIM   = US_CNT_W'(RXWIN_US);
  localparam logic [US_CNT_W-1:0] STALL_LIM = US_CNT_W'(RXSTALL_US);

  pk_state_e           state_q, state_d;
  logic [US_CNT_W-1:0] us_cnt_q, us_cnt_d;
  logic                trl_pend_q, trl_pend_d;
  logic                after_tx_q, after_tx_d;
  logic                hdr_q;
  logic                tx_st, rx_trl, rx_to, txarm_enter, rx_done_ok, addr_flag;
  logic [US_CNT_W-1:0] us_cnt_inc;

  assign us_cnt_inc = us_sat_inc(us_cnt_q, p_1us);

  always_comb begin
    state_d     = state_q;
    us_cnt_d    = us_cnt_q;
    trl_pend_d  = trl_pend_q;
    after_tx_d  = after_tx_q;
    tx_st       = 1'b0;
    rx_trl      = 1'b0;
    rx_to       = 1'b0;
    txarm_enter = 1'b0;
    rx_done_ok  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_tslot_p) begin
          if (master ? !slot_odd : (slot_odd && addr_flag)) begin
            state_d     = ST_TXARM;
            txarm_enter = 1'b1;
          end else if (master ? slot_odd : !slot_odd) begin
            state_d  = ST_RXWIN;
            us_cnt_d = '0;
          end
        end
      end
      ST_TXARM: begin
        if (p_1us) begin
          tx_st   = 1'b1;
          state_d = ST_TX;
        end
      end
      ST_TX: begin
        if (hdr_q && !hdr_period) begin
          state_d    = ST_IDLE;
          after_tx_d = 1'b1;
        end
      end
      ST_RXWIN: begin
        us_cnt_d = us_cnt_inc;
        // A hit in the expiry cycle takes precedence over the timeout.
        if (corr_hit_p) begin
          state_d    = ST_RX;
          us_cnt_d   = '0;
          trl_pend_d = 1'b1;
        end else if (us_cnt_q >= WIN_LIM) begin
          state_d    = ST_IDLE;
          rx_to      = 1'b1;
          after_tx_d = 1'b0;
        end
      end
      ST_RX: begin
        us_cnt_d = us_cnt_inc;
        if (trl_pend_q && p_1us) begin
          rx_trl     = 1'b1;
          trl_pend_d = 1'b0;
        end
        if (rx_done_p) begin
          state_d    = ST_IDLE;
          rx_done_ok = 1'b1;
          trl_pend_d = 1'b0;
          after_tx_d = 1'b0;
        end else if (us_cnt_q >= STALL_LIM) begin
          state_d    = ST_IDLE;
          rx_to      = 1'b1;
          trl_pend_d = 1'b0;
          after_tx_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!conns) begin
      state_d     = ST_IDLE;
      trl_pend_d  = 1'b0;
      tx_st       = 1'b0;
      rx_trl      = 1'b0;
      rx_to       = 1'b0;
      txarm_enter = 1'b0;
      rx_done_ok  = 1'b0;
    end
  end

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state_q    <= ST_IDLE;
      us_cnt_q   <= '0;
      trl_pend_q <= 1'b0;
      after_tx_q <= 1'b0;
      hdr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      us_cnt_q   <= us_cnt_d;
      trl_pend_q <= trl_pend_d;
      after_tx_q <= after_tx_d;
      hdr_q      <= hdr_period;
    end
  end

  arq_track u_arq (
    .clk_i          (clk_6M),
    .rst_ni         (rstz),
    .rx_done_i      (rx_done_ok),
    .lt_addressed_i (lt_addressed),
    .rx_arqn_i      (rx_arqn),
    .rx_seqn_i      (rx_seqn),
    .rx_crc_good_i  (rx_crc_good),
    .tx_pending_i   (tx_pending),
    .retx_i         (rx_to && after_tx_q),
    .slave_i        (!master),
    .txarm_enter_i  (txarm_enter),
    .txarqn_o       (txarqn),
    .txseqn_o       (txseqn),
    .tx_new_o       (tx_new),
    .addr_flag_o    (addr_flag)
  );

  assign tx_packet_st_p  = tx_st;
  assign rx_trailer_st_p = rx_trl;
  assign rx_timeout_p    = rx_to;
  assign pk_encode       = (state_q == ST_TXARM) || (state_q == ST_TX);
  assign rx_window       = (state_q == ST_RXWIN);

endmodule

// File: tb/tb_pkslot_ctrl.sv
// Directed bench for pkslot_ctrl; pulse outputs are checked through an expectation queue.
module tb_pkslot_ctrl;

  logic clk_6M = 1'b0;
  logic rstz = 1'b0, p_1us = 1'b0, s_tslot_p = 1'b0, slot_odd = 1'b0, conns = 1'b0;
  logic master = 1'b0, tx_pending = 1'b0, corr_hit_p = 1'b0, hdr_period = 1'b0;
  logic lt_addressed = 1'b0, rx_arqn = 1'b0, rx_seqn = 1'b0, rx_crc_good = 1'b0, rx_done_p = 1'b0;
  logic tx_packet_st_p, rx_trailer_st_p, pk_encode, rx_window;
  logic txarqn, txseqn, tx_new, rx_timeout_p;

  int checks = 0;
  int failures = 0;
  int us_tick = 0;

  localparam int EV_TX  = 0;
  localparam int EV_TRL = 1;
  localparam int EV_TO  = 2;

  typedef struct {
    int kind;
    int tick;
    bit on_us;
  } ev_t;
  ev_t exp_q[$];

  pkslot_ctrl #(.RXWIN_US(20), .RXSTALL_US(400)) dut (
    .clk_6M          (clk_6M),
    .rstz            (rstz),
    .p_1us           (p_1us),
    .s_tslot_p       (s_tslot_p),
    .slot_odd        (slot_odd),
    .conns           (conns),
    .master          (master),
    .tx_pending      (tx_pending),
    .corr_hit_p      (corr_hit_p),
    .hdr_period      (hdr_period),
    .lt_addressed    (lt_addressed),
    .rx_arqn         (rx_arqn),
    .rx_seqn         (rx_seqn),
    .rx_crc_good     (rx_crc_good),
    .rx_done_p       (rx_done_p),
    .tx_packet_st_p  (tx_packet_st_p),
    .rx_trailer_st_p (rx_trailer_st_p),
    .pk_encode       (pk_encode),
    .rx_window       (rx_window),
    .txarqn          (txarqn),
    .txseqn          (txseqn),
    .tx_new          (tx_new),
    .rx_timeout_p    (rx_timeout_p)
  );

  always #83 clk_6M = ~clk_6M;

  // 1-us strobe: one cycle in six, updated just after the rising edge.
  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk_6M);
      #1;
      if (div == 5) begin
        div = 0;
        p_1us = 1'b1;
        us_tick = us_tick + 1;
      end else begin
        div = div + 1;
        p_1us = 1'b0;
      end
    end
  end

  task automatic see(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_pulse kind=%0d tick=%0d required=no_pulse", kind, us_tick);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.tick != us_tick || e.on_us != p_1us) begin
        failures++;
        $display("FAIL pulse got kind=%0d tick=%0d on_us=%0b required kind=%0d tick=%0d on_us=%0b",
                 kind, us_tick, p_1us, e.kind, e.tick, e.on_us);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk_6M);
      if (tx_packet_st_p === 1'b1)  see(EV_TX);
      if (rx_trailer_st_p === 1'b1) see(EV_TRL);
      if (rx_timeout_p === 1'b1)    see(EV_TO);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_6M);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int tick, input bit on_us);
    ev_t e;
    e.kind = kind;
    e.tick = tick;
    e.on_us = on_us;
    exp_q.push_back(e);
  endtask

  task automatic till_tick(input int t);
    int guard;
    guard = 0;
    while (us_tick < t && guard < 5000) begin
      step();
      guard++;
    end
  endtask

  task automatic slot(input logic odd, output int t0);
    s_tslot_p = 1'b1;
    slot_odd = odd;
    t0 = us_tick;
    step();
    s_tslot_p = 1'b0;
  endtask

  task automatic hit();
    corr_hit_p = 1'b1;
    step();
    corr_hit_p = 1'b0;
  endtask

  task automatic rxdone(input logic addr, input logic crc, input logic arqn, input logic seqn);
    lt_addressed = addr;
    rx_crc_good = crc;
    rx_arqn = arqn;
    rx_seqn = seqn;
    rx_done_p = 1'b1;
    step();
    rx_done_p = 1'b0;
    lt_addressed = 1'b0;
    rx_crc_good = 1'b0;
    rx_arqn = 1'b0;
    step(2);
  endtask

  task automatic tx_slot(input logic odd);
    int t0;
    slot(odd, t0);
    expect_ev(EV_TX, t0 + 1, 1'b1);
    step(8);
    chk("pk_encode_in_tx", pk_encode, 1'b1);
    hdr_period = 1'b1;
    step(20);
    chk("pk_encode_hdr", pk_encode, 1'b1);
    hdr_period = 1'b0;
    step(2);
    chk("pk_encode_after_hdr_fall", pk_encode, 1'b0);
  endtask

  task automatic rx_hit_slot(input logic odd, input int at);
    int t0;
    slot(odd, t0);
    till_tick(t0 + at);
    expect_ev(EV_TRL, t0 + at + 1, 1'b1);
    hit();
    step(8);
  endtask

  initial begin
    int t0;
    step(3);
    chk("rst_pk_encode", pk_encode, 1'b0);
    chk("rst_rx_window", rx_window, 1'b0);
    chk("rst_txarqn", txarqn, 1'b0);
    chk("rst_txseqn", txseqn, 1'b1);
    chk("rst_tx_new", tx_new, 1'b1);
    rstz = 1'b1;
    conns = 1'b1;
    master = 1'b1;
    tx_pending = 1'b1;
    step(4);

    // Master even slot transmits
    tx_slot(1'b0);

    // Master odd slot, hit at 12 us, acked reply
    slot(1'b1, t0);
    chk("rxwin_open", rx_window, 1'b1);
    till_tick(t0 + 12);
    expect_ev(EV_TRL, t0 + 13, 1'b1);
    hit();
    step(8);
    rxdone(1'b1, 1'b1, 1'b1, 1'b0);
    chk("ack_txseqn", txseqn, 1'b0);
    chk("ack_txarqn", txarqn, 1'b1);
    chk("ack_tx_new", tx_new, 1'b1);
    chk("ack_rx_window", rx_window, 1'b0);

    // Search window expiry without a preceding tx keeps tx_new
    slot(1'b1, t0);
    expect_ev(EV_TO, t0 + 20, 1'b0);
    till_tick(t0 + 22);
    chk("to_rx_window", rx_window, 1'b0);
    chk("to_no_tx_tx_new", tx_new, 1'b1);

    // NAK with duplicate SEQN, then bad CRC, then fresh ack
    tx_slot(1'b0);
    rx_hit_slot(1'b1, 6);
    rxdone(1'b1, 1'b1, 1'b0, 1'b0);
    chk("nak_txseqn", txseqn, 1'b0);
    chk("nak_tx_new", tx_new, 1'b0);
    chk("dup_txarqn", txarqn, 1'b1);
    rx_hit_slot(1'b1, 6);
    rxdone(1'b1, 1'b0, 1'b0, 1'b0);
    chk("badcrc_txarqn", txarqn, 1'b0);
    rx_hit_slot(1'b1, 6);
    rxdone(1'b1, 1'b1, 1'b1, 1'b1);
    chk("ack2_txarqn", txarqn, 1'b1);
    chk("ack2_txseqn", txseqn, 1'b1);
    chk("ack2_tx_new", tx_new, 1'b1);

    // Timeout after a tx forces retransmit
    tx_slot(1'b0);
    slot(1'b1, t0);
    expect_ev(EV_TO, t0 + 20, 1'b0);
    till_tick(t0 + 22);
    chk("retx_tx_new", tx_new, 1'b0);
    chk("retx_txseqn", txseqn, 1'b1);

    // Hit coincident with window expiry wins; unaddressed rx changes nothing
    slot(1'b1, t0);
    till_tick(t0 + 20);
    step();
    expect_ev(EV_TRL, t0 + 21, 1'b1);
    hit();
    step(8);
    rxdone(1'b0, 1'b1, 1'b1, 1'b0);
    chk("race_txarqn", txarqn, 1'b1);
    chk("race_txseqn", txseqn, 1'b1);
    chk("race_tx_new", tx_new, 1'b0);

    // Slot strobe during the window is ignored
    slot(1'b1, t0);
    expect_ev(EV_TO, t0 + 20, 1'b0);
    till_tick(t0 + 5);
    s_tslot_p = 1'b1;
    step();
    s_tslot_p = 1'b0;
    till_tick(t0 + 22);
    chk("ignore_slot_rx_window", rx_window, 1'b0);

    // Rx stall timeout after 400 us in RX
    slot(1'b1, t0);
    till_tick(t0 + 3);
    expect_ev(EV_TRL, t0 + 4, 1'b1);
    expect_ev(EV_TO, t0 + 403, 1'b0);
    hit();
    till_tick(t0 + 405);
    chk("stall_pk_encode", pk_encode, 1'b0);
    chk("stall_rx_window", rx_window, 1'b0);

    // Slave: addressed rx in even slot enables reply in odd slot, once
    master = 1'b0;
    tx_pending = 1'b0;
    rx_hit_slot(1'b0, 4);
    rxdone(1'b1, 1'b1, 1'b1, 1'b0);
    chk("slave_txseqn", txseqn, 1'b0);
    chk("slave_tx_new", tx_new, 1'b0);
    tx_slot(1'b1);
    slot(1'b1, t0);
    step(10);
    chk("slave_flag_consumed", pk_encode, 1'b0);
    rx_hit_slot(1'b0, 4);
    rxdone(1'b0, 1'b1, 1'b1, 1'b1);
    chk("slave_unaddr_txseqn", txseqn, 1'b0);
    slot(1'b1, t0);
    step(10);
    chk("slave_unaddr_no_tx", pk_encode, 1'b0);

    // Reset in the middle of TX
    master = 1'b1;
    slot(1'b0, t0);
    expect_ev(EV_TX, t0 + 1, 1'b1);
    step(8);
    hdr_period = 1'b1;
    step(3);
    rstz = 1'b0;
    step(2);
    chk("midrst_pk_encode", pk_encode, 1'b0);
    chk("midrst_txseqn", txseqn, 1'b1);
    chk("midrst_txarqn", txarqn, 1'b0);
    chk("midrst_tx_new", tx_new, 1'b1);
    hdr_period = 1'b0;
    step(2);
    rstz = 1'b1;
    step(30);
    chk("postrst_pk_encode", pk_encode, 1'b0);

    // conns dropped during the search window, then during RX
    slot(1'b1, t0);
    till_tick(t0 + 4);
    conns = 1'b0;
    step(2);
    chk("conns_off_rx_window", rx_window, 1'b0);
    conns = 1'b1;
    slot(1'b1, t0);
    till_tick(t0 + 5);
    hit();
    conns = 1'b0;
    step(2);
    conns = 1'b1;
    till_tick(t0 + 30);
    chk("conns_off_rx_idle", rx_window, 1'b0);
    chk("conns_off_txseqn", txseqn, 1'b1);

    step(12);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses got_pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
